mem_access_stage: RTL and testbench

//  MIPS pipeline memory-access (MA) stage. Owns the byte-addressable data memory.

---
 rtl/mem_access_stage.sv | 108 ++++++++++
 tb/tb_mem_access_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: byte-addressable data memory with lane-selected stores,
// sign/zero-extended loads, sticky misalignment capture and a raw debug read port.
module mem_access_stage #(
  parameter int NBITS     = 32,
  parameter int ADDR_BITS = 7
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [1:0]           i_width,
  input  logic                 i_unsigned,
  input  logic                 i_stall,
  input  logic [NBITS-1:0]     i_addr,
  input  logic [NBITS-1:0]     i_wdata,
  input  logic [ADDR_BITS-1:0] i_dbg_addr,
  output logic [NBITS-1:0]     o_rdata,
  output logic [NBITS-1:0]     o_dbg_data,
  output logic                 o_misalign,
  output logic [NBITS-1:0]     o_fault_addr
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int LANES = NBITS / 8;

  // Every word must clear on reset, so the array is built from flops, not block RAM.
  logic [NBITS-1:0] r_mem [DEPTH];
  logic             r_misalign;
  logic [NBITS-1:0] r_fault_addr;

  logic [ADDR_BITS-1:0] w_word_idx;
  logic [1:0]           w_lane;
  logic                 w_aligned;
  logic [LANES-1:0]     w_byte_en;
  logic [NBITS-1:0]     w_wdata_rep;
  logic [NBITS-1:0]     w_word;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [NBITS-1:0]     w_load;
  logic                 w_store;
  logic                 w_unused_addr_bits;

  assign w_word_idx         = i_addr[ADDR_BITS+1:2];
  assign w_lane             = i_addr[1:0];
  assign w_unused_addr_bits = ^i_addr[NBITS-1:ADDR_BITS+2];

  always_comb begin
    w_aligned   = 1'b1;
    w_byte_en   = '1;
    w_wdata_rep = i_wdata;
    case (i_width)
      2'b00: begin
        w_byte_en   = LANES'(1) << w_lane;
        w_wdata_rep = {LANES{i_wdata[7:0]}};
      end
      2'b01: begin
        w_aligned   = ~w_lane[0];
        w_byte_en   = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{i_wdata[15:0]}};
      end
      default: w_aligned = (w_lane == 2'b00);  // 11 word, 10 reserved treated as word
    endcase
  end

  assign w_store = i_mem_write & ~i_stall & w_aligned;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int w = 0; w < DEPTH; w++) r_mem[w] <= '0;
    end else if (w_store) begin
      for (int l = 0; l < LANES; l++)
        if (w_byte_en[l]) r_mem[w_word_idx][8*l +: 8] <= w_wdata_rep[8*l +: 8];
    end
  end

  // First misaligned access wins; only reset releases the flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_misalign   <= 1'b0;
      r_fault_addr <= '0;
    end else if ((i_mem_read | i_mem_write) & ~w_aligned & ~i_stall & ~r_misalign) begin
      r_misalign   <= 1'b1;
      r_fault_addr <= i_addr;
    end
  end

  always_comb begin
    w_word = r_mem[w_word_idx];
    case (w_lane)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
    case (i_width)
      2'b00:   w_load = {{(NBITS-8){~i_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{(NBITS-16){~i_unsigned & w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  assign o_rdata      = (i_mem_read & w_aligned) ? w_load : '0;
  assign o_dbg_data   = r_mem[i_dbg_addr];
  assign o_misalign   = r_misalign;
  assign o_fault_addr = r_fault_addr;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stores, extended loads, misalignment capture,
// stall, aliasing, read/write ordering and reset priority.
module tb_mem_access_stage;

  logic        i_clk = 1'b0;
  logic        i_rst, i_mem_read, i_mem_write, i_unsigned, i_stall;
  logic [1:0]  i_width;
  logic [31:0] i_addr, i_wdata;
  logic [6:0]  i_dbg_addr;
  logic [31:0] o_rdata, o_dbg_data, o_fault_addr;
  logic        o_misalign;

  int checks = 0;
  int errors = 0;

  mem_access_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_width(i_width), .i_unsigned(i_unsigned), .i_stall(i_stall), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_dbg_addr(i_dbg_addr), .o_rdata(o_rdata), .o_dbg_data(o_dbg_data),
    .o_misalign(o_misalign), .o_fault_addr(o_fault_addr)
  );

  always #5 i_clk = ~i_clk;

  task automatic idle();
    i_mem_read = 0; i_mem_write = 0; i_stall = 0; i_unsigned = 0;
    i_width = 2'b11; i_addr = 0; i_wdata = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                       input logic st);
    @(negedge i_clk);
    i_mem_write = 1; i_mem_read = 0; i_addr = a; i_wdata = d; i_width = w; i_stall = st;
    @(posedge i_clk); #1;
    idle();
    $display("store addr=%h data=%h width=%b stall=%b", a, d, w, st);
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] w, input logic u);
    @(negedge i_clk);
    i_mem_write = 0; i_mem_read = 1; i_addr = a; i_width = w; i_unsigned = u;
    #1;
    $display("load  addr=%h width=%b unsigned=%b rdata=%h", a, w, u, o_rdata);
  endtask

  task automatic peek(input logic [6:0] wa);
    i_dbg_addr = wa; #1;
  endtask

  task automatic test_reset();
    load(32'h0, 2'b11, 0);
    checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp %h", o_rdata, 32'h0); end
    idle(); peek(7'd2);
    checks++; if (o_dbg_data !== 32'h0) begin errors++; $display("FAIL reset_dbg got %h exp %h", o_dbg_data, 32'h0); end
    checks++; if (o_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", o_misalign); end
    checks++; if (o_fault_addr !== 32'h0) begin errors++; $display("FAIL reset_fault got %h exp 0", o_fault_addr); end
  endtask

  task automatic test_word();
    store(32'h8, 32'hDEADBEEF, 2'b11, 0);
    load(32'h8, 2'b11, 0);
    checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_8 got %h exp %h", o_rdata, 32'hDEADBEEF); end
    load(32'h8, 2'b11, 1);
    checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_8_uns got %h exp %h", o_rdata, 32'hDEADBEEF); end
    peek(7'd2);
    checks++; if (o_dbg_data !== 32'hDEADBEEF) begin errors++; $display("FAIL dbg_2 got %h exp %h", o_dbg_data, 32'hDEADBEEF); end
    idle();
    load(32'h8, 2'b11, 0); i_mem_read = 0; #1;
    checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL no_read got %h exp 0", o_rdata); end
  endtask

  task automatic test_byte();
    store(32'h9, 32'hFFFFFF11, 2'b00, 0);
    peek(7'd2);
    checks++; if (o_dbg_data !== 32'hDEAD11EF) begin errors++; $display("FAIL sb_9 got %h exp %h", o_dbg_data, 32'hDEAD11EF); end
    load(32'h9, 2'b00, 0);
    checks++; if (o_rdata !== 32'h00000011) begin errors++; $display("FAIL lb_9 got %h exp %h", o_rdata, 32'h11); end
    load(32'hB, 2'b00, 0);
    checks++; if (o_rdata !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb_b got %h exp %h", o_rdata, 32'hFFFFFFDE); end
    load(32'hB, 2'b00, 1);
    checks++; if (o_rdata !== 32'h000000DE) begin errors++; $display("FAIL lbu_b got %h exp %h", o_rdata, 32'hDE); end
    load(32'h8, 2'b00, 0);
    checks++; if (o_rdata !== 32'hFFFFFFEF) begin errors++; $display("FAIL lb_8 got %h exp %h", o_rdata, 32'hFFFFFFEF); end
    idle();
  endtask

  task automatic test_half_misalign();
    store(32'hA, 32'h12348001, 2'b01, 0);
    peek(7'd2);
    checks++; if (o_dbg_data !== 32'h800111EF) begin errors++; $display("FAIL sh_a got %h exp %h", o_dbg_data, 32'h800111EF); end
    load(32'hA, 2'b01, 0);
    checks++; if (o_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_a got %h exp %h", o_rdata, 32'hFFFF8001); end
    load(32'hA, 2'b01, 1);
    checks++; if (o_rdata !== 32'h00008001) begin errors++; $display("FAIL lhu_a got %h exp %h", o_rdata, 32'h8001); end
    load(32'h8, 2'b01, 0);
    checks++; if (o_rdata !== 32'h000011EF) begin errors++; $display("FAIL lh_8 got %h exp %h", o_rdata, 32'h11EF); end
    idle();
    store(32'h5, 32'hFFFFFFFF, 2'b01, 0);
    peek(7'd1);
    checks++; if (o_dbg_data !== 32'h0) begin errors++; $display("FAIL sh_5_nowrite got %h exp 0", o_dbg_data); end
    checks++; if (o_misalign !== 1'b1) begin errors++; $display("FAIL sh_5_flag got %b exp 1", o_misalign); end
    checks++; if (o_fault_addr !== 32'h5) begin errors++; $display("FAIL sh_5_addr got %h exp 5", o_fault_addr); end
    load(32'h6, 2'b11, 0);
    checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL lw_6 got %h exp 0", o_rdata); end
    @(posedge i_clk); #1;
    idle();
    checks++; if (o_fault_addr !== 32'h5) begin errors++; $display("FAIL fault_sticky got %h exp 5", o_fault_addr); end
    load(32'hB, 2'b01, 0);
    checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL lh_b got %h exp 0", o_rdata); end
    idle();
  endtask

  task automatic test_stall_alias();
    store(32'h4, 32'hCAFEF00D, 2'b11, 1);
    peek(7'd1);
    checks++; if (o_dbg_data !== 32'h0) begin errors++; $display("FAIL sw_stall got %h exp 0", o_dbg_data); end
    store(32'h4, 32'hCAFEF00D, 2'b11, 0);
    peek(7'd1);
    checks++; if (o_dbg_data !== 32'hCAFEF00D) begin errors++; $display("FAIL sw_4 got %h exp %h", o_dbg_data, 32'hCAFEF00D); end
    store(32'h204, 32'h12345678, 2'b11, 0);
    peek(7'd1);
    checks++; if (o_dbg_data !== 32'h12345678) begin errors++; $display("FAIL sw_alias got %h exp %h", o_dbg_data, 32'h12345678); end
    store(32'hC, 32'hA5A5A5A5, 2'b10, 0);
    peek(7'd3);
    checks++; if (o_dbg_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL sw_w10 got %h exp %h", o_dbg_data, 32'hA5A5A5A5); end
    store(32'hF, 32'h0000007E, 2'b00, 0);
    peek(7'd3);
    checks++; if (o_dbg_data !== 32'h7EA5A5A5) begin errors++; $display("FAIL sb_f got %h exp %h", o_dbg_data, 32'h7EA5A5A5); end
  endtask

  task automatic test_back_to_back();
    @(negedge i_clk);
    i_mem_read = 1; i_mem_write = 1; i_addr = 32'h10; i_wdata = 32'h1234; i_width = 2'b11;
    #1;
    checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL rw_old got %h exp 0", o_rdata); end
    @(posedge i_clk); #1;
    i_mem_write = 0; #1;
    checks++; if (o_rdata !== 32'h1234) begin errors++; $display("FAIL rw_new got %h exp %h", o_rdata, 32'h1234); end
    $display("rw    addr=10 data=1234 rdata_next=%h", o_rdata);
    idle();
  endtask

  task automatic test_reset_priority();
    @(negedge i_clk);
    i_rst = 1; i_mem_write = 1; i_addr = 32'h0; i_wdata = 32'hFFFFFFFF; i_width = 2'b11;
    @(posedge i_clk); #1;
    i_rst = 0; idle();
    peek(7'd0);
    checks++; if (o_dbg_data !== 32'h0) begin errors++; $display("FAIL rst_word0 got %h exp 0", o_dbg_data); end
    peek(7'd2);
    checks++; if (o_dbg_data !== 32'h0) begin errors++; $display("FAIL rst_word2 got %h exp 0", o_dbg_data); end
    checks++; if (o_misalign !== 1'b0) begin errors++; $display("FAIL rst_flag got %b exp 0", o_misalign); end
    checks++; if (o_fault_addr !== 32'h0) begin errors++; $display("FAIL rst_fault got %h exp 0", o_fault_addr); end
    $display("reset with SW 0 FFFFFFFF applied");
  endtask

  initial begin
    idle(); i_dbg_addr = 0; i_rst = 1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 0;
    test_reset();
    test_word();
    test_byte();
    test_half_misalign();
    test_stall_alias();
    test_back_to_back();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
